sram_ctrl: RTL and testbench

- Bridges the core's 32-bit load/store port to the 16-bit asynchronous SRAM bus (SRAM_ADDR/SRAM_DQ/CE_N/WE_N/OE_N/LB_N/UB_N).
- Each word access is sequenced as a low-halfword phase followed by a high-halfword phase, with a parameterised wait-state count per phase.
- Sits between the LSU and the board SRAM pins. Uses a ready/ack handshake toward the LSU.

---
 rtl/sram_ctrl_pkg.sv | 24 ++
 rtl/sram_wait_cnt.sv | 32 +++
 rtl/sram_ctrl.sv | 171 +++++++++++++++++
 tb/tb_sram_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and bus widths for the 32-bit to 16-bit SRAM bridge.
package sram_ctrl_pkg;

   localparam int SRAM_AW = 18;
   localparam int SRAM_DW = 16;
   localparam int BUS_W   = 32;
   localparam int MASK_W  = 4;

   // Width of the word index carried into the SRAM address (byte address bits [18:2]).
   localparam int WORD_AW = SRAM_AW - 1;

   typedef enum logic [1:0] {
      IDLE,
      LO,
      HI,
      DONE
   } state_t;

   // A write phase is only worth running when at least one of its byte lanes is enabled.
   function automatic logic lanes_active(input logic [1:0] lanes);
      return |lanes;
   endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// sram_wait_cnt: per-phase wait-state counter. Counts 0..WAIT_CYCLES after each load and
// then holds, flagging the final phase cycle and the end of the write-enable window.
module sram_wait_cnt
   import sram_ctrl_pkg::*;
#(
   parameter int WAIT_CYCLES = 1   // legal range 1..15
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_load,
   output logic o_last,
   output logic o_first_n
);

   localparam int CW = 4;

   logic [CW-1:0] count;

   // Restart at every phase boundary, then count up and saturate at WAIT_CYCLES.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_load) begin
         count <= '0;
      end else if (!o_last) begin
         count <= count + 1'b1;
      end
   end

   assign o_last    = (count == CW'(WAIT_CYCLES));
   // Active-low write window: low while the strobe may be asserted, high on the closing cycle.
   assign o_first_n = (count >= CW'(WAIT_CYCLES));

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: bridges the LSU 32-bit load/store port to a 16-bit asynchronous SRAM.
// Each word access runs a low-halfword phase then a high-halfword phase, each lasting
// WAIT_CYCLES+1 clocks. Optional macro SRAM_CTRL_ERR_EN enables misaligned-access
// rejection through o_err; without it o_err is tied low and i_addr[1:0] is ignored.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_req,
   input  logic                i_we,
   input  logic [BUS_W-1:0]    i_addr,
   input  logic [BUS_W-1:0]    i_wdata,
   input  logic [MASK_W-1:0]   i_bmask,
   output logic                o_ready,
   output logic                o_ack,
   output logic [BUS_W-1:0]    o_rdata,
   output logic                o_err,
   output logic [SRAM_AW-1:0]  SRAM_ADDR,
   inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
   output logic                SRAM_CE_N,
   output logic                SRAM_WE_N,
   output logic                SRAM_OE_N,
   output logic                SRAM_LB_N,
   output logic                SRAM_UB_N
);

   state_t               state;
   state_t               state_next;
   logic                 accept;
   logic                 misaligned;
   logic                 cnt_load;
   logic                 cnt_last;
   logic                 cnt_first_n;
   logic                 we_r;
   logic [WORD_AW-1:0]   word_r;
   logic [BUS_W-1:0]     wdata_r;
   logic [MASK_W-1:0]    bmask_r;
   logic                 err_r;
   logic [SRAM_DW-1:0]   lo_buf;
   logic                 in_phase;
   logic                 in_hi;
   logic [1:0]           lanes;
   logic                 dq_drive;
   logic [SRAM_DW-1:0]   dq_out;
   logic                 addr_unused;

`ifdef SRAM_CTRL_ERR_EN
   assign misaligned  = |i_addr[1:0];
   assign addr_unused = ^i_addr[BUS_W-1:19];
`else
   assign misaligned  = 1'b0;
   assign addr_unused = ^{i_addr[BUS_W-1:19], i_addr[1:0]};
`endif

   assign o_ready = (state == IDLE) && !i_rst;
   assign accept  = i_req && o_ready;

   // Any state change marks a phase boundary, so the wait counter restarts for the new phase.
   assign cnt_load = (state_next != state);

   sram_wait_cnt #(
      .WAIT_CYCLES(WAIT_CYCLES)
   ) u_wait_cnt (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_load    (cnt_load),
      .o_last    (cnt_last),
      .o_first_n (cnt_first_n)
   );

   // State register; reset aborts any access in flight without an acknowledge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Sequencing: write phases with no enabled lanes are skipped, rejected requests go straight to DONE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (misaligned) begin
                  state_next = DONE;
               end else if (i_we && !lanes_active(i_bmask[1:0]) && !lanes_active(i_bmask[3:2])) begin
                  state_next = DONE;
               end else if (i_we && !lanes_active(i_bmask[1:0])) begin
                  state_next = HI;
               end else begin
                  state_next = LO;
               end
            end
         end
         LO: begin
            if (cnt_last) begin
               state_next = (we_r && !lanes_active(bmask_r[3:2])) ? DONE : HI;
            end
         end
         HI: begin
            if (cnt_last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
      endcase
   end

   // Capture the whole request on acceptance so the LSU may change its inputs afterwards.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         we_r    <= 1'b0;
         word_r  <= '0;
         wdata_r <= '0;
         bmask_r <= '0;
         err_r   <= 1'b0;
      end else if (accept) begin
         we_r    <= i_we;
         word_r  <= i_addr[18:2];
         wdata_r <= i_wdata;
         bmask_r <= i_bmask;
         err_r   <= misaligned;
      end
   end

   // Read data is sampled on the last cycle of each phase; o_rdata only changes as the ack arrives.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         lo_buf  <= '0;
         o_rdata <= '0;
      end else if (!we_r && cnt_last) begin
         if (state == LO) begin
            lo_buf <= SRAM_DQ;
         end else if (state == HI) begin
            o_rdata <= {SRAM_DQ, lo_buf};
         end
      end
   end

   assign o_ack = (state == DONE);
   assign o_err = (state == DONE) && err_r;

   // SRAM pin decode from the current phase; all strobes idle high outside LO/HI.
   always_comb begin
      in_phase  = (state == LO) || (state == HI);
      in_hi     = (state == HI);
      lanes     = in_hi ? bmask_r[3:2] : bmask_r[1:0];
      dq_out    = in_hi ? wdata_r[31:16] : wdata_r[15:0];
      dq_drive  = in_phase && we_r;
      SRAM_ADDR = in_phase ? {word_r, in_hi} : '0;
      SRAM_CE_N = !in_phase;
      SRAM_OE_N = !(in_phase && !we_r);
      SRAM_WE_N = dq_drive ? cnt_first_n : 1'b1;
      SRAM_LB_N = 1'b1;
      SRAM_UB_N = 1'b1;
      if (in_phase) begin
         SRAM_LB_N = we_r ? !lanes[0] : 1'b0;
         SRAM_UB_N = we_r ? !lanes[1] : 1'b0;
      end
   end

   assign SRAM_DQ = dq_drive ? dq_out : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: self-checking bench for sram_ctrl with a behavioural SRAM on the pins and a
// word-level reference memory for randomized traffic. Honors SRAM_CTRL_ERR_EN if defined.
module tb_sram_ctrl;

   localparam int W  = 1;
   localparam int PH = W + 1;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        req   = 1'b0;
   logic        we    = 1'b0;
   logic [31:0] addr  = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  mask  = '0;
   logic        ready, ack, err;
   logic [31:0] rdata;
   logic [17:0] sram_addr;
   wire  [15:0] sram_dq;
   logic        ce_n, we_n, oe_n, lb_n, ub_n;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sram_ctrl #(.WAIT_CYCLES(W)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_req     (req),
      .i_we      (we),
      .i_addr    (addr),
      .i_wdata   (wdata),
      .i_bmask   (mask),
      .o_ready   (ready),
      .o_ack     (ack),
      .o_rdata   (rdata),
      .o_err     (err),
      .SRAM_ADDR (sram_addr),
      .SRAM_DQ   (sram_dq),
      .SRAM_CE_N (ce_n),
      .SRAM_WE_N (we_n),
      .SRAM_OE_N (oe_n),
      .SRAM_LB_N (lb_n),
      .SRAM_UB_N (ub_n)
   );

   // Behavioural asynchronous SRAM plus a trace of every cycle where chip enable is low.
   logic [15:0] sram_mem [int];
   logic        model_drive = 1'b0;
   logic [15:0] model_rd    = '0;
   logic [15:0] cur_half;

   typedef struct {
      logic [17:0] a;
      logic [15:0] d;
      logic        we_n;
      logic        oe_n;
      logic        lb_n;
      logic        ub_n;
   } ev_t;
   ev_t trace[$];

   assign sram_dq = model_drive ? model_rd : 16'hzzzz;

   function automatic logic [15:0] mem_rd(input logic [17:0] a);
      if (sram_mem.exists(int'(a))) return sram_mem[int'(a)];
      return 16'h0000;
   endfunction

   // Mid-cycle sampling of the pins: log activity, perform writes, and drive read data.
   always @(negedge clk) begin
      if (!ce_n) begin
         trace.push_back('{a: sram_addr, d: sram_dq, we_n: we_n, oe_n: oe_n, lb_n: lb_n, ub_n: ub_n});
         if (!we_n) begin
            cur_half = mem_rd(sram_addr);
            if (!lb_n) cur_half[7:0]  = sram_dq[7:0];
            if (!ub_n) cur_half[15:8] = sram_dq[15:8];
            sram_mem[int'(sram_addr)] = cur_half;
         end
      end
      model_drive <= !ce_n && !oe_n && we_n;
      model_rd    <= mem_rd(sram_addr);
   end

   // Expected ack latency from the access rules: one cycle for DONE plus PH per active phase.
   function automatic int exp_lat(input logic w, input logic [3:0] m, input logic [1:0] low);
      int ph;
`ifdef SRAM_CTRL_ERR_EN
      if (low != 2'b00) return 1;
`else
      if (low != 2'b00) ph = 0;
`endif
      if (!w) ph = 2;
      else    ph = ((m[1:0] != 2'b00) ? 1 : 0) + ((m[3:2] != 2'b00) ? 1 : 0);
      return 1 + ph * PH;
   endfunction

   // Single access; starts and ends #1 after a rising edge with the controller idle.
   task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] m, output int lat, output logic [31:0] rd,
                            output logic er);
      int guard;
      req = 1'b1; we = w; addr = a; wdata = d; mask = m;
      guard = 0;
      while (!ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      @(posedge clk); #1;
      req = 1'b0;
      lat = 1;
      while (!ack && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = rdata;
      er = err;
      if (!ack) lat = -1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b want=0", ready); end
      total++;
      if ({ack, err} !== 2'b00) begin bad++; $display("[TB] FAIL reset_ack_err got=%b want=00", {ack, err}); end
      total++;
      if (rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata got=%h want=0", rdata); end
      total++;
      if (sram_addr !== 18'h0) begin bad++; $display("[TB] FAIL reset_addr got=%h want=0", sram_addr); end
      total++;
      if ({ce_n, we_n, oe_n, lb_n, ub_n} !== 5'b11111) begin
         bad++; $display("[TB] FAIL reset_strobes got=%b want=11111", {ce_n, we_n, oe_n, lb_n, ub_n});
      end
      rst = 1'b0;
      #1;
      total++;
      if (ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_release_ready got=%b want=1", ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_write_full();
      int lat; logic [31:0] rd; logic er;
      trace.delete();
      do_access(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, lat, rd, er);
      total++;
      if (lat != 1 + 2 * PH) begin bad++; $display("[TB] FAIL wr_full_latency got=%0d want=%0d", lat, 1 + 2 * PH); end
      total++;
      if (trace.size() != 2 * PH) begin bad++; $display("[TB] FAIL wr_full_cycles got=%0d want=%0d", trace.size(), 2 * PH); end
      for (int i = 0; i < trace.size() && i < 2 * PH; i++) begin
         logic [17:0] ea;
         logic [15:0] ed;
         logic        ewe;
         ea  = (i < PH) ? 18'h00080 : 18'h00081;
         ed  = (i < PH) ? 16'hBEEF : 16'hDEAD;
         ewe = ((i % PH) == PH - 1);
         total++;
         if (trace[i].a !== ea || trace[i].d !== ed || trace[i].we_n !== ewe || trace[i].oe_n !== 1'b1
             || trace[i].lb_n !== 1'b0 || trace[i].ub_n !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wr_full_pins[%0d] got a=%h d=%h we_n=%b oe_n=%b lb=%b ub=%b want a=%h d=%h we_n=%b oe_n=1 lb=0 ub=0",
                     i, trace[i].a, trace[i].d, trace[i].we_n, trace[i].oe_n, trace[i].lb_n, trace[i].ub_n, ea, ed, ewe);
         end
      end
   endtask

   task automatic test_read();
      int lat; logic [31:0] rd; logic er;
      trace.delete();
      do_access(1'b0, 32'h100, 32'h0, 4'hF, lat, rd, er);
      total++;
      if (rd !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL rd_data got=%h want=deadbeef", rd); end
      total++;
      if (lat != 1 + 2 * PH) begin bad++; $display("[TB] FAIL rd_latency got=%0d want=%0d", lat, 1 + 2 * PH); end
      total++;
      if (trace.size() != 2 * PH) begin bad++; $display("[TB] FAIL rd_cycles got=%0d want=%0d", trace.size(), 2 * PH); end
      for (int i = 0; i < trace.size(); i++) begin
         total++;
         if (trace[i].oe_n !== 1'b0 || trace[i].we_n !== 1'b1 || trace[i].lb_n !== 1'b0 || trace[i].ub_n !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rd_strobes[%0d] got oe_n=%b we_n=%b lb=%b ub=%b want 0 1 0 0",
                     i, trace[i].oe_n, trace[i].we_n, trace[i].lb_n, trace[i].ub_n);
         end
      end
   endtask

   task automatic test_partial_write();
      int lat; logic [31:0] rd; logic er;
      trace.delete();
      do_access(1'b1, 32'h104, 32'h00AB0000, 4'b0100, lat, rd, er);
      total++;
      if (lat != 1 + PH) begin bad++; $display("[TB] FAIL part_latency got=%0d want=%0d", lat, 1 + PH); end
      total++;
      if (trace.size() != PH) begin bad++; $display("[TB] FAIL part_cycles got=%0d want=%0d", trace.size(), PH); end
      for (int i = 0; i < trace.size(); i++) begin
         total++;
         if (trace[i].a !== 18'h00083 || trace[i].d !== 16'h00AB || trace[i].lb_n !== 1'b0 || trace[i].ub_n !== 1'b1) begin
            bad++;
            $display("[TB] FAIL part_pins[%0d] got a=%h d=%h lb=%b ub=%b want a=00083 d=00ab lb=0 ub=1",
                     i, trace[i].a, trace[i].d, trace[i].lb_n, trace[i].ub_n);
         end
      end
      do_access(1'b0, 32'h104, 32'h0, 4'hF, lat, rd, er);
      total++;
      if (rd !== 32'h00AB0000) begin bad++; $display("[TB] FAIL part_readback got=%h want=00ab0000", rd); end
   endtask

   task automatic test_zero_mask();
      int lat; logic [31:0] rd; logic er;
      trace.delete();
      do_access(1'b1, 32'h108, 32'hFFFFFFFF, 4'b0000, lat, rd, er);
      total++;
      if (lat != 1) begin bad++; $display("[TB] FAIL zero_mask_latency got=%0d want=1", lat); end
      total++;
      if (trace.size() != 0) begin bad++; $display("[TB] FAIL zero_mask_ce_activity got=%0d want=0", trace.size()); end
   endtask

   task automatic test_back_to_back();
      int acc[$];
      int acks;
      acks = 0;
      req = 1'b1; we = 1'b0; addr = 32'h100; mask = 4'hF;
      for (int c = 0; c < 60 && acc.size() < 3; c++) begin
         if (ready) acc.push_back(c);
         if (ack) acks++;
         @(posedge clk); #1;
      end
      req = 1'b0;
      for (int c = 0; c < 20 && acks < 3; c++) begin
         @(posedge clk); #1;
         if (ack) acks++;
      end
      @(posedge clk); #1;
      total++;
      if (acc.size() != 3) begin
         bad++; $display("[TB] FAIL b2b_accepts got=%0d want=3", acc.size());
      end else begin
         total++;
         if (acc[1] - acc[0] != 2 * PH + 2) begin bad++; $display("[TB] FAIL b2b_spacing1 got=%0d want=%0d", acc[1] - acc[0], 2 * PH + 2); end
         total++;
         if (acc[2] - acc[1] != 2 * PH + 2) begin bad++; $display("[TB] FAIL b2b_spacing2 got=%0d want=%0d", acc[2] - acc[1], 2 * PH + 2); end
      end
      total++;
      if (acks != 3) begin bad++; $display("[TB] FAIL b2b_acks got=%0d want=3", acks); end
   endtask

   task automatic test_misaligned();
      int lat; logic [31:0] rd; logic er;
      trace.delete();
      do_access(1'b0, 32'h102, 32'h0, 4'hF, lat, rd, er);
      total++;
      if (rd !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL misalign_rdata got=%h want=deadbeef", rd); end
`ifdef SRAM_CTRL_ERR_EN
      total++;
      if (lat != 1) begin bad++; $display("[TB] FAIL misalign_latency got=%0d want=1", lat); end
      total++;
      if (er !== 1'b1) begin bad++; $display("[TB] FAIL misalign_err got=%b want=1", er); end
      total++;
      if (trace.size() != 0) begin bad++; $display("[TB] FAIL misalign_ce_activity got=%0d want=0", trace.size()); end
`else
      total++;
      if (lat != 1 + 2 * PH) begin bad++; $display("[TB] FAIL misalign_latency got=%0d want=%0d", lat, 1 + 2 * PH); end
      total++;
      if (er !== 1'b0) begin bad++; $display("[TB] FAIL misalign_err got=%b want=0", er); end
      total++;
      if (trace.size() != 2 * PH) begin bad++; $display("[TB] FAIL misalign_cycles got=%0d want=%0d", trace.size(), 2 * PH); end
`endif
   endtask

   task automatic test_reset_mid();
      int  waited;
      int  ack_seen;
      req = 1'b1; we = 1'b1; addr = 32'h300; wdata = 32'h12345678; mask = 4'hF;
      @(posedge clk); #1;
      req = 1'b0;
      waited = 0;
      while (sram_addr !== 18'h00181 && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      total++;
      if (sram_addr !== 18'h00181) begin bad++; $display("[TB] FAIL midrst_reach_hi got=%h want=00181", sram_addr); end
      rst = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({ce_n, we_n, oe_n, lb_n, ub_n} !== 5'b11111) begin
         bad++; $display("[TB] FAIL midrst_strobes got=%b want=11111", {ce_n, we_n, oe_n, lb_n, ub_n});
      end
      total++;
      if ({ack, ready} !== 2'b00) begin bad++; $display("[TB] FAIL midrst_ack_ready got=%b want=00", {ack, ready}); end
      rst = 1'b0;
      #1;
      total++;
      if (ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_ready_after got=%b want=1", ready); end
      ack_seen = 0;
      for (int c = 0; c < 2 * PH + 2; c++) begin
         @(posedge clk); #1;
         if (ack) ack_seen++;
      end
      total++;
      if (ack_seen != 0) begin bad++; $display("[TB] FAIL midrst_no_ack got=%0d want=0", ack_seen); end
   endtask

   task automatic test_random();
      logic [31:0] ref_mem [8];
      int          lat;
      logic [31:0] rd;
      logic        er;
      for (int i = 0; i < 8; i++) ref_mem[i] = 32'h0;
      for (int n = 0; n < 40; n++) begin
         int          idx;
         logic        w;
         logic [3:0]  m;
         logic [31:0] d;
         idx = int'($urandom_range(0, 7));
         w   = 1'($urandom_range(0, 1));
         m   = 4'($urandom);
         d   = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         do_access(w, 32'h2000 + 32'(idx * 4), d, m, lat, rd, er);
         total++;
         if (lat != exp_lat(w, m, 2'b00)) begin
            bad++; $display("[TB] FAIL rand_latency[%0d] we=%b mask=%b got=%0d want=%0d", n, w, m, lat, exp_lat(w, m, 2'b00));
         end
         total++;
         if (er !== 1'b0) begin bad++; $display("[TB] FAIL rand_err[%0d] got=%b want=0", n, er); end
         if (w) begin
            for (int b = 0; b < 4; b++) begin
               if (m[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
            end
         end else begin
            total++;
            if (rd !== ref_mem[idx]) begin bad++; $display("[TB] FAIL rand_rdata[%0d] word=%0d got=%h want=%h", n, idx, rd, ref_mem[idx]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_full();
      test_read();
      test_partial_write();
      test_zero_mask();
      test_back_to_back();
      test_misaligned();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
